mfp_irq_ctrl: RTL and testbench

- Interrupt controller and arbiter for the MFP: collects 16 single-cycle interrupt events (timer A–D pulses, GPIP edges, USART events).
- Latches events into pending registers and applies enable, mask and in-service priority gating.
- Drives a single request line to the CPU.
- Answers the CPU interrupt-acknowledge cycle with an 8-bit vector, sequencing pending→in-service bookkeeping.

---
 rtl/mfp_irq_pkg.sv | 24 ++
 rtl/mfp_irq_prio.sv | 27 ++
 rtl/mfp_irq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mfp_irq_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_irq_pkg.sv
// mfp_irq_pkg: shared definitions for the MFP interrupt controller.
//   - register select codes for REG_SEL
//   - vector returned when an acknowledge finds no eligible source
//   - acknowledge sequencer state type and encodings
package mfp_irq_pkg;

  localparam logic [3:0] REG_IERA = 4'd0;
  localparam logic [3:0] REG_IERB = 4'd1;
  localparam logic [3:0] REG_IPRA = 4'd2;
  localparam logic [3:0] REG_IPRB = 4'd3;
  localparam logic [3:0] REG_ISRA = 4'd4;
  localparam logic [3:0] REG_ISRB = 4'd5;
  localparam logic [3:0] REG_IMRA = 4'd6;
  localparam logic [3:0] REG_IMRB = 4'd7;
  localparam logic [3:0] REG_VR   = 4'd8;

  localparam logic [7:0] SPURIOUS_VEC = 8'h18;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ARB  = 2'd1;
  localparam state_t VEC  = 2'd2;

endpackage

// File: rtl/mfp_irq_prio.sv
// mfp_irq_prio: combinational priority resolver.
//   i_req [15:0] : pending-and-unmasked sources
//   i_isr [15:0] : in-service bits; a source is eligible only above the
//                  highest in-service bit
//   o_any        : at least one source eligible
//   o_win [3:0]  : highest eligible index (0 when o_any is low)
module mfp_irq_prio (
  input  logic [15:0] i_req,
  input  logic [15:0] i_isr,
  output logic        o_any,
  output logic [3:0]  o_win
);

  logic [15:0] w_elig;

  always_comb begin
    w_elig = '0;
    o_win  = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      // no in-service bit at or above k
      w_elig[k] = i_req[k] & ((i_isr >> k) == 16'd0);
      if (w_elig[k]) o_win = 4'(k);
    end
    o_any = |w_elig;
  end

endmodule

// File: rtl/mfp_irq_ctrl.sv
// mfp_irq_ctrl: 16-source interrupt controller / arbiter for the MFP.
// Ports:
//   CLK, RST (async, active-high)
//   SRC_I[15:0]  event pulses (15 = highest priority)
//   REG_SEL/REG_WE/REG_DI/REG_DO  register access (IER/IPR/ISR/IMR A,B; VR)
//   IRQ          registered interrupt request
//   IACK         acknowledge pulse
//   VEC_VALID, VEC_O, SPURIOUS  acknowledge response
// Build option: define MFP_IRQ_SYNC_EN to pass SRC_I[7:0] through a
// 2-flop synchronizer with rising-edge detect (+2 CLK latency).
module mfp_irq_ctrl
  import mfp_irq_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] SRC_I,
  input  logic [3:0]  REG_SEL,
  input  logic        REG_WE,
  input  logic [7:0]  REG_DI,
  output logic [7:0]  REG_DO,
  output logic        IRQ,
  input  logic        IACK,
  output logic        VEC_VALID,
  output logic [7:0]  VEC_O,
  output logic        SPURIOUS
);

  logic [15:0] r_ier, r_ipr, r_isr, r_imr;
  logic [7:4]  r_vr_base;
  logic        r_vr_s;
  state_t      r_state;
  logic        r_irq, r_vv, r_spur;
  logic [7:0]  r_vec;

  logic [15:0] w_evt, w_req;
  logic [15:0] w_ier_nxt, w_ipr_nxt, w_isr_nxt, w_imr_nxt;
  logic [7:4]  w_base_nxt;
  logic        w_s_nxt;
  logic        w_any;
  logic [3:0]  w_win;

`ifdef MFP_IRQ_SYNC_EN
  logic [7:0] r_sync1, r_sync2, r_sync3;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= SRC_I[7:0];
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_evt = {SRC_I[15:8], r_sync2 & ~r_sync3};
`else
  assign w_evt = SRC_I;
`endif

  assign w_req = r_ipr & r_imr;

  mfp_irq_prio u_prio (
    .i_req (w_req),
    .i_isr (r_isr),
    .o_any (w_any),
    .o_win (w_win)
  );

  always_comb begin
    w_ier_nxt  = r_ier;
    w_ipr_nxt  = r_ipr;
    w_isr_nxt  = r_isr;
    w_imr_nxt  = r_imr;
    w_base_nxt = r_vr_base;
    w_s_nxt    = r_vr_s;
    if (REG_WE) begin
      case (REG_SEL)
        REG_IERA: w_ier_nxt[15:8] = REG_DI;
        REG_IERB: w_ier_nxt[7:0]  = REG_DI;
        REG_IPRA: w_ipr_nxt[15:8] = r_ipr[15:8] & REG_DI;
        REG_IPRB: w_ipr_nxt[7:0]  = r_ipr[7:0] & REG_DI;
        REG_ISRA: w_isr_nxt[15:8] = r_isr[15:8] & REG_DI;
        REG_ISRB: w_isr_nxt[7:0]  = r_isr[7:0] & REG_DI;
        REG_IMRA: w_imr_nxt[15:8] = REG_DI;
        REG_IMRB: w_imr_nxt[7:0]  = REG_DI;
        REG_VR: begin
          w_base_nxt = REG_DI[7:4];
          w_s_nxt    = REG_DI[3];
          if (!REG_DI[3]) w_isr_nxt = '0;
        end
        default: ;
      endcase
    end
    // disabling a source discards anything it had pending
    w_ipr_nxt = w_ipr_nxt & w_ier_nxt;
    // Acknowledge bookkeeping is committed on the ARB->VEC edge so the
    // cleared IPR is visible in the same cycle VEC_VALID is presented.
    if (r_state == ARB && w_any) begin
      w_ipr_nxt[w_win] = 1'b0;
      if (r_vr_s) w_isr_nxt[w_win] = 1'b1;
    end
    // a new event beats any clear in the same cycle
    w_ipr_nxt = w_ipr_nxt | (w_evt & w_ier_nxt);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ier     <= '0;
      r_ipr     <= '0;
      r_isr     <= '0;
      r_imr     <= '0;
      r_vr_base <= '0;
      r_vr_s    <= 1'b0;
    end else begin
      r_ier     <= w_ier_nxt;
      r_ipr     <= w_ipr_nxt;
      r_isr     <= w_isr_nxt;
      r_imr     <= w_imr_nxt;
      r_vr_base <= w_base_nxt;
      r_vr_s    <= w_s_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_irq   <= 1'b0;
      r_vv    <= 1'b0;
      r_spur  <= 1'b0;
      r_vec   <= '0;
    end else begin
      r_irq  <= w_any;
      r_vv   <= 1'b0;
      r_spur <= 1'b0;
      case (r_state)
        IDLE: if (IACK) r_state <= ARB;
        ARB: begin
          r_state <= VEC;
          r_vv    <= 1'b1;
          r_spur  <= ~w_any;
          r_vec   <= w_any ? {r_vr_base, w_win} : SPURIOUS_VEC;
        end
        VEC:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    REG_DO = '0;
    case (REG_SEL)
      REG_IERA: REG_DO = r_ier[15:8];
      REG_IERB: REG_DO = r_ier[7:0];
      REG_IPRA: REG_DO = r_ipr[15:8];
      REG_IPRB: REG_DO = r_ipr[7:0];
      REG_ISRA: REG_DO = r_isr[15:8];
      REG_ISRB: REG_DO = r_isr[7:0];
      REG_IMRA: REG_DO = r_imr[15:8];
      REG_IMRB: REG_DO = r_imr[7:0];
      REG_VR:   REG_DO = {r_vr_base, r_vr_s, 3'b000};
      default:  REG_DO = '0;
    endcase
  end

  assign IRQ       = r_irq;
  assign VEC_VALID = r_vv;
  assign VEC_O     = r_vec;
  assign SPURIOUS  = r_spur;

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// tb_mfp_irq_ctrl: directed bench for mfp_irq_ctrl with a cycle model
// compared on every falling edge, plus literal expectations per scenario.
`timescale 1ns/100ps
module tb_mfp_irq_ctrl;

  logic        CLK, RST;
  logic [15:0] SRC_I;
  logic [3:0]  REG_SEL;
  logic        REG_WE;
  logic [7:0]  REG_DI, REG_DO;
  logic        IRQ, IACK, VEC_VALID, SPURIOUS;
  logic [7:0]  VEC_O;

  int n_checks = 0;
  int n_err    = 0;

  mfp_irq_ctrl dut (
    .CLK(CLK), .RST(RST), .SRC_I(SRC_I), .REG_SEL(REG_SEL), .REG_WE(REG_WE),
    .REG_DI(REG_DI), .REG_DO(REG_DO), .IRQ(IRQ), .IACK(IACK),
    .VEC_VALID(VEC_VALID), .VEC_O(VEC_O), .SPURIOUS(SPURIOUS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_ier, m_ipr, m_isr, m_imr;
  logic [7:0]  m_vr, m_vec;
  logic        m_irq, m_vv, m_spur;
  int          m_phase;  // 0 waiting, 1 arbitrating, 2 presenting
  logic [7:0]  m_h1, m_h2, m_h3;
  logic [15:0] t_evt, t_ier, t_ipr, t_isr, t_imr;
  logic [7:0]  t_vr;
  int          t_w;

  // highest pending+unmasked source strictly above the highest in-service one
  function automatic int winner(input logic [15:0] ipr, imr, isr);
    int top = -1;
    int res = -1;
    for (int i = 0; i < 16; i++) if (isr[i]) top = i;
    for (int i = 0; i < 16; i++) if (i > top && ipr[i] && imr[i]) res = i;
    return res;
  endfunction

  function automatic logic [7:0] model_read(input logic [3:0] sel);
    case (sel)
      4'd0: return m_ier[15:8];
      4'd1: return m_ier[7:0];
      4'd2: return m_ipr[15:8];
      4'd3: return m_ipr[7:0];
      4'd4: return m_isr[15:8];
      4'd5: return m_isr[7:0];
      4'd6: return m_imr[15:8];
      4'd7: return m_imr[7:0];
      4'd8: return m_vr;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_ier = '0; m_ipr = '0; m_isr = '0; m_imr = '0; m_vr = '0;
      m_vec = '0; m_irq = 0; m_vv = 0; m_spur = 0; m_phase = 0;
      m_h1 = '0; m_h2 = '0; m_h3 = '0;
    end else begin
      t_w   = winner(m_ipr, m_imr, m_isr);
      t_evt = SRC_I;
`ifdef MFP_IRQ_SYNC_EN
      t_evt[7:0] = m_h2 & ~m_h3;
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = SRC_I[7:0];
`endif
      t_ier = m_ier; t_ipr = m_ipr; t_isr = m_isr; t_imr = m_imr; t_vr = m_vr;
      if (REG_WE) begin
        case (REG_SEL)
          4'd0: t_ier[15:8] = REG_DI;
          4'd1: t_ier[7:0]  = REG_DI;
          4'd2: t_ipr[15:8] = t_ipr[15:8] & REG_DI;
          4'd3: t_ipr[7:0]  = t_ipr[7:0] & REG_DI;
          4'd4: t_isr[15:8] = t_isr[15:8] & REG_DI;
          4'd5: t_isr[7:0]  = t_isr[7:0] & REG_DI;
          4'd6: t_imr[15:8] = REG_DI;
          4'd7: t_imr[7:0]  = REG_DI;
          4'd8: begin
            t_vr = REG_DI & 8'hF8;
            if (!REG_DI[3]) t_isr = '0;
          end
          default: ;
        endcase
      end
      t_ipr = t_ipr & t_ier;
      m_vv = 0; m_spur = 0;
      if (m_phase == 1) begin
        m_vv = 1;
        if (t_w < 0) begin
          m_vec = 8'h18; m_spur = 1;
        end else begin
          m_vec = {m_vr[7:4], 4'(t_w)};
          t_ipr[t_w] = 1'b0;
          if (m_vr[3]) t_isr[t_w] = 1'b1;
        end
      end
      t_ipr = t_ipr | (t_evt & t_ier);
      m_irq = (t_w >= 0);
      case (m_phase)
        0: if (IACK) m_phase = 1;
        1: m_phase = 2;
        default: m_phase = 0;
      endcase
      m_ier = t_ier; m_ipr = t_ipr; m_isr = t_isr; m_imr = t_imr; m_vr = t_vr;
    end
  end

  always @(negedge CLK) begin
    check("irq", IRQ, m_irq);
    check("vec_valid", VEC_VALID, m_vv);
    check("vec_o", VEC_O, m_vec);
    check("spurious", SPURIOUS, m_spur);
    check("reg_do", REG_DO, model_read(REG_SEL));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    REG_SEL = a; REG_DI = d; REG_WE = 1'b1;
    step();
    REG_WE = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
    REG_SEL = a;
    #0.1;
    check(name, REG_DO, exp);
  endtask

  task automatic ack();
    IACK = 1'b1;
    step();
    IACK = 1'b0;
    step();
  endtask

  initial begin
    RST = 1'b1; SRC_I = '0; REG_SEL = '0; REG_WE = 1'b0; REG_DI = '0; IACK = 1'b0;
    step(); step();
    check("rst_irq", IRQ, 0);
    check("rst_vv", VEC_VALID, 0);
    check("rst_vec", VEC_O, 8'h00);
    check("rst_spur", SPURIOUS, 0);
    for (int s = 0; s < 9; s++) rd_chk("rst_reg", 4'(s), 8'h00);
    RST = 1'b0;
    step();

    // basic request / acknowledge on source 13
    wr(4'd0, 8'h20); wr(4'd6, 8'h20); wr(4'd8, 8'h47);
    rd_chk("vr_low_bits", 4'd8, 8'h40);
    rd_chk("reserved_sel", 4'd9, 8'h00);
    SRC_I = 16'h2000; step(); SRC_I = '0;
    rd_chk("t1_ipra_n1", 4'd2, 8'h20);
    check("t1_irq_n1", IRQ, 0);
    step();
    check("t1_irq_n2", IRQ, 1);
    IACK = 1'b1; step(); IACK = 1'b0;
    check("t1_vv_arb", VEC_VALID, 0);
    step();
    check("t1_vv", VEC_VALID, 1);
    check("t1_vec", VEC_O, 8'h4D);
    check("t1_spur", SPURIOUS, 0);
    rd_chk("t1_ipra", 4'd2, 8'h00);
    step();
    check("t1_irq_clr", IRQ, 0);
    check("t1_vec_hold", VEC_O, 8'h4D);

    // software EOI: in-service blocks lower sources
    wr(4'd8, 8'h48); wr(4'd1, 8'h20); wr(4'd7, 8'h20);
    SRC_I = 16'h2020; step(); SRC_I = '0; step();
    check("t2_irq", IRQ, 1);
    ack();
    check("t2_vv", VEC_VALID, 1);
    check("t2_vec", VEC_O, 8'h4D);
    rd_chk("t2_isra", 4'd4, 8'h20);
    rd_chk("t2_isrb", 4'd5, 8'h00);
    step();
    check("t2_irq_blocked", IRQ, 0);
    rd_chk("t2_iprb", 4'd3, 8'h20);
    wr(4'd0, 8'h28); wr(4'd6, 8'h28);
    SRC_I = 16'h0800; step(); SRC_I = '0; step(); step();
    check("t2_irq_11_blocked", IRQ, 0);
    rd_chk("t2_ipra_11", 4'd2, 8'h08);
    wr(4'd4, 8'hDF);
    check("t2_irq_pre", IRQ, 0);
    step();
    check("t2_irq_11", IRQ, 1);
    ack();
    check("t2_vec11", VEC_O, 8'h4B);
    rd_chk("t2_isra_11", 4'd4, 8'h08);
    wr(4'd8, 8'h40);
    rd_chk("t2_isr_cleared", 4'd4, 8'h00);
    wr(4'd3, 8'h00);

    // masked source: spurious acknowledge
    wr(4'd1, 8'h04); wr(4'd7, 8'h00);
    SRC_I = 16'h0004; step(); SRC_I = '0; step();
    check("t3_irq", IRQ, 0);
    rd_chk("t3_iprb", 4'd3, 8'h04);
    ack();
    check("t3_vv", VEC_VALID, 1);
    check("t3_vec", VEC_O, 8'h18);
    check("t3_spur", SPURIOUS, 1);
    rd_chk("t3_iprb_kept", 4'd3, 8'h04);

    // same-cycle collisions
    wr(4'd1, 8'h14);
    SRC_I = 16'h0010; wr(4'd3, 8'hEF); SRC_I = '0;
    rd_chk("t4_set_wins", 4'd3, 8'h14);
    SRC_I = 16'h0010; wr(4'd1, 8'h00); SRC_I = '0;
    rd_chk("t4_disable_wins", 4'd3, 8'h00);

    // reset during arbitration
    SRC_I = 16'h2000; step(); SRC_I = '0; step();
    check("t5_irq", IRQ, 1);
    IACK = 1'b1; step(); IACK = 1'b0;
    RST = 1'b1; #1;
    check("t5_vv_rst", VEC_VALID, 0);
    step();
    RST = 1'b0;
    check("t5_irq_rst", IRQ, 0);
    check("t5_vv_after", VEC_VALID, 0);
    for (int s = 0; s < 9; s++) rd_chk("t5_reg", 4'(s), 8'h00);
    step();
    check("t5_vv_later", VEC_VALID, 0);

    // back-to-back acknowledges: one vector per 3 CLK
    wr(4'd0, 8'h28); wr(4'd6, 8'h28); wr(4'd8, 8'h40);
    SRC_I = 16'h2800; step(); SRC_I = '0; step();
    IACK = 1'b1;
    step(); step();
    check("t6_vv1", VEC_VALID, 1);
    check("t6_vec1", VEC_O, 8'h4D);
    step();
    check("t6_vv_gap", VEC_VALID, 0);
    step(); step();
    check("t6_vv2", VEC_VALID, 1);
    check("t6_vec2", VEC_O, 8'h4B);
    IACK = 1'b0;
    step();

    // source 0 event latency
    wr(4'd1, 8'h01);
`ifdef MFP_IRQ_SYNC_EN
    SRC_I = 16'h0001;
    step(); rd_chk("t7_sync_c1", 4'd3, 8'h00);
    step(); rd_chk("t7_sync_c2", 4'd3, 8'h00);
    step(); rd_chk("t7_sync_c3", 4'd3, 8'h01);
    wr(4'd3, 8'hFE);
    rd_chk("t7_sync_clr", 4'd3, 8'h00);
    repeat (6) step();
    SRC_I = '0;
    rd_chk("t7_sync_once", 4'd3, 8'h00);
    step(); step();
    rd_chk("t7_sync_fall", 4'd3, 8'h00);
`else
    SRC_I = 16'h0001; step(); SRC_I = '0;
    rd_chk("t7_direct", 4'd3, 8'h01);
    step();
`endif
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
